complex_integrate_dump: RTL

//   Integrate-and-dump accumulator for complex samples. It sits directly downstream of the

---
 rtl/complex_integrate_dump.sv | 113 +++++++++++
 1 files changed

// File: rtl/complex_integrate_dump.sv
// Integrate-and-dump accumulator for complex samples: sums N = len_i+1 valid
// samples per frame and emits one full-precision {re, im} sum per frame.
module complex_integrate_dump #(
    parameter int unsigned IN_WIDTH  = 22,
    parameter int unsigned LEN_WIDTH = 10,
    localparam int unsigned OUT_WIDTH = IN_WIDTH + LEN_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LEN_WIDTH-1:0]   len_i,
    input  logic                   clear_i,
    input  logic                   valid_i,
    input  logic [2*IN_WIDTH-1:0]  a_i,
    output logic [2*OUT_WIDTH-1:0] c_o,
    output logic                   valid_o,
    output logic                   busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t                 state;
    logic signed [OUT_WIDTH-1:0] acc_re;
    logic signed [OUT_WIDTH-1:0] acc_im;
    logic [LEN_WIDTH-1:0]   cnt;
    logic [LEN_WIDTH-1:0]   len_q;

    logic signed [IN_WIDTH-1:0]  a_re;
    logic signed [IN_WIDTH-1:0]  a_im;
    logic signed [OUT_WIDTH-1:0] a_re_ext;
    logic signed [OUT_WIDTH-1:0] a_im_ext;
    logic signed [OUT_WIDTH-1:0] sum_re;
    logic signed [OUT_WIDTH-1:0] sum_im;
    logic                        last_c;

    // Sign-extended sample and running sum including the current sample.
    assign a_re     = a_i[2*IN_WIDTH-1:IN_WIDTH];
    assign a_im     = a_i[IN_WIDTH-1:0];
    assign a_re_ext = OUT_WIDTH'(a_re);
    assign a_im_ext = OUT_WIDTH'(a_im);
    assign sum_re   = acc_re + a_re_ext;
    assign sum_im   = acc_im + a_im_ext;

    // cnt holds the index of the last accepted sample; this sample closes the frame.
    assign last_c   = (cnt == LEN_WIDTH'(len_q - LEN_WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc_re  <= '0;
            acc_im  <= '0;
            cnt     <= '0;
            len_q   <= '0;
            c_o     <= '0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (clear_i) begin
                // Abort: drop any partial frame and any sample arriving with the clear.
                state  <= IDLE;
                acc_re <= '0;
                acc_im <= '0;
                cnt    <= '0;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (valid_i) begin
                            len_q <= len_i;
                            cnt   <= '0;
                            if (len_i == '0) begin
                                c_o     <= {a_re_ext, a_im_ext};
                                valid_o <= 1'b1;
                                acc_re  <= '0;
                                acc_im  <= '0;
                            end else begin
                                acc_re <= a_re_ext;
                                acc_im <= a_im_ext;
                                state  <= ACC;
                                busy_o <= 1'b1;
                            end
                        end
                    end
                    ACC: begin
                        if (valid_i) begin
                            if (last_c) begin
                                c_o     <= {sum_re, sum_im};
                                valid_o <= 1'b1;
                                acc_re  <= '0;
                                acc_im  <= '0;
                                cnt     <= '0;
                                state   <= IDLE;
                                busy_o  <= 1'b0;
                            end else begin
                                acc_re <= sum_re;
                                acc_im <= sum_im;
                                cnt    <= LEN_WIDTH'(cnt + LEN_WIDTH'(1));
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
